time_bcd_split: RTL

//  Sequential binary-to-BCD splitter for the two traffic countdown values.

---
 rtl/time_bcd_split.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/time_bcd_split.sv
// time_bcd_split: sequential binary-to-BCD splitter for the two traffic
// countdown values. A double-dabble engine converts channel A and then
// channel B one bit per cycle, and all four digits plus ovf are written
// in a single commit cycle. The display therefore never sees a partially
// converted pair.
//
// Ports
//   clk_50M    in   1       system clock, sole clock domain
//   reset_btn  in   1       synchronous, active-high reset
//   a_time     in   TIME_W  direction-A remaining time, binary
//   b_time     in   TIME_W  direction-B remaining time, binary
//   a_tens     out  4       A tens digit (BCD, or 4'hF when blanked)
//   a_ones     out  4       A ones digit (BCD)
//   b_tens     out  4       B tens digit (BCD, or 4'hF when blanked)
//   b_ones     out  4       B ones digit (BCD)
//   busy       out  1       high while a conversion is in progress
//   upd        out  1       one-cycle pulse on the cycle the digits change
//   ovf        out  1       last committed snapshot had a or b above 99
//
// Parameters
//   TIME_W    width of each binary time input (1..7)
//   BLANK_LZ  when 1, a zero tens digit is presented as 4'hF (blank code)

module time_bcd_split #(
  parameter int unsigned TIME_W   = 6,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic              clk_50M,
  input  logic              reset_btn,
  input  logic [TIME_W-1:0] a_time,
  input  logic [TIME_W-1:0] b_time,
  output logic [3:0]        a_tens,
  output logic [3:0]        a_ones,
  output logic [3:0]        b_tens,
  output logic [3:0]        b_ones,
  output logic              busy,
  output logic              upd,
  output logic              ovf
);

  // One conversion step per input bit, channel A first, then channel B.
  localparam int unsigned STEPS  = 2 * TIME_W;
  localparam int unsigned STEP_W = $clog2(STEPS + 1);
  localparam int unsigned IN_W   = 2 * TIME_W;
  localparam int unsigned BCD_W  = 8;
  localparam int unsigned CMP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;

  logic                pending_q;
  logic [TIME_W-1:0]   snap_a_q;
  logic [TIME_W-1:0]   snap_b_q;
  logic [IN_W-1:0]     work_q;
  logic [STEP_W-1:0]   step_q;
  logic [BCD_W-1:0]    acc_a_q;
  logic [BCD_W-1:0]    acc_b_q;

  logic                start_c;
  logic                last_step_c;
  logic                chan_a_c;
  logic                load_c;
  logic                step_c;
  logic                commit_c;
  logic [BCD_W-1:0]    adj_a_c;
  logic [BCD_W-1:0]    adj_b_c;
  logic                sat_a_c;
  logic                sat_b_c;
  logic [7:0]          fin_a_c;
  logic [7:0]          fin_b_c;

  // Add 3 to every nibble that is 5 or more, ahead of the left shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  // Final digit pair: saturate to 99 when out of range, then optional blanking.
  function automatic logic [7:0] final_digits(input logic [BCD_W-1:0] bcd,
                                              input logic             sat);
    logic [3:0] t;
    logic [3:0] o;
    t = sat ? 4'd9 : bcd[7:4];
    o = sat ? 4'd9 : bcd[3:0];
    if (BLANK_LZ && (t == 4'd0)) t = 4'hF;
    return {t, o};
  endfunction

  // Start a conversion after reset or whenever the inputs leave the snapshot.
  assign start_c     = pending_q || ({a_time, b_time} != {snap_a_q, snap_b_q});
  assign last_step_c = (step_q == STEP_W'(STEPS - 1));
  assign chan_a_c    = (step_q < STEP_W'(TIME_W));

  assign adj_a_c = bcd_adjust(acc_a_q);
  assign adj_b_c = bcd_adjust(acc_b_q);

  // Range check uses the binary snapshot; the 8-bit accumulator wraps above 99.
  assign sat_a_c = (CMP_W'(snap_a_q) > CMP_W'(99));
  assign sat_b_c = (CMP_W'(snap_b_q) > CMP_W'(99));

  assign fin_a_c = final_digits(acc_a_q, sat_a_c);
  assign fin_b_c = final_digits(acc_b_q, sat_b_c);

  // State register.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_c) state_d = ST_CONV;
      ST_CONV:   if (last_step_c) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE:   load_c   = start_c;
      ST_CONV:   step_c   = 1'b1;
      ST_COMMIT: commit_c = 1'b1;
      default:   ;
    endcase
  end

  // Snapshot, shift engine and registered outputs.
  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      pending_q <= 1'b1;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      work_q    <= '0;
      step_q    <= '0;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      a_tens    <= 4'd0;
      a_ones    <= 4'd0;
      b_tens    <= 4'd0;
      b_ones    <= 4'd0;
      busy      <= 1'b0;
      upd       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      upd <= 1'b0;

      if (load_c) begin
        pending_q <= 1'b0;
        snap_a_q  <= a_time;
        snap_b_q  <= b_time;
        work_q    <= {a_time, b_time};
        step_q    <= '0;
        acc_a_q   <= '0;
        acc_b_q   <= '0;
        busy      <= 1'b1;
      end

      // work_q MSB is always the next snapshot bit to shift in.
      if (step_c) begin
        work_q <= work_q << 1;
        step_q <= step_q + STEP_W'(1);
        if (chan_a_c) begin
          acc_a_q <= BCD_W'(adj_a_c << 1) | {{(BCD_W-1){1'b0}}, work_q[IN_W-1]};
        end else begin
          acc_b_q <= BCD_W'(adj_b_c << 1) | {{(BCD_W-1){1'b0}}, work_q[IN_W-1]};
        end
      end

      if (commit_c) begin
        a_tens <= fin_a_c[7:4];
        a_ones <= fin_a_c[3:0];
        b_tens <= fin_b_c[7:4];
        b_ones <= fin_b_c[3:0];
        ovf    <= sat_a_c || sat_b_c;
        upd    <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule
